// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register-file geometry and the word/index types
// passed between the ID, pipeline-register and writeback stages.
package pipe_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_COUNT  = 2 ** REG_ADDR_W;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0]     word_t;

  // Writeback control bundle as carried by the MEM/WB register.
  typedef struct packed {
    logic     wreg;
    logic     m2reg;
    reg_idx_t rn;
  } wb_ctrl_t;

  function automatic logic is_zero_idx(input reg_idx_t idx);
    return idx == REG_ZERO;
  endfunction

endpackage

// File: rtl/pipe_regfile.sv
// General register file: r0 reads as zero, one write port, two combinational
// read ports with same-cycle write-through bypass.
module pipe_regfile #(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int ADDR_W = pipe_pkg::REG_ADDR_W
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b
);
  import pipe_pkg::*;

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_reg [NREG];

  // Asynchronous clear keeps this in fabric registers rather than block RAM.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREG; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (wr_en && (wr_addr != '0)) begin
      regs_reg[wr_addr] <= wr_data;
    end
  end

  logic [1:0][ADDR_W-1:0] rd_addr;
  assign rd_addr = {rd_addr_b, rd_addr_a};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic [DATA_W-1:0] q;
      always_comb begin
        q = regs_reg[rd_addr[gi]];
        if (rd_addr[gi] == '0) begin
          q = '0;
        end else if (wr_en && (rd_addr[gi] == wr_addr)) begin
          q = wr_data;
        end
      end
    end
  endgenerate

  assign rd_data_a = g_rd[0].q;
  assign rd_data_b = g_rd[1].q;

endmodule

// File: rtl/pipe_wb_stage.sv
// Writeback stage: selects memory or ALU data, commits it to the register file
// and counts retired register writes with a saturating counter.
module pipe_wb_stage #(
  parameter int DATA_W  = pipe_pkg::DATA_W,
  parameter int ADDR_W  = pipe_pkg::REG_ADDR_W,
  parameter int COUNT_W = 32
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               wwreg,
  input  logic               wm2reg,
  input  logic [DATA_W-1:0]  wmo,
  input  logic [DATA_W-1:0]  walu,
  input  logic [ADDR_W-1:0]  wrn,
  input  logic [ADDR_W-1:0]  rna,
  input  logic [ADDR_W-1:0]  rnb,
  input  logic               cnt_clr,
  output logic [DATA_W-1:0]  qa,
  output logic [DATA_W-1:0]  qb,
  output logic [DATA_W-1:0]  wdi,
  output logic [COUNT_W-1:0] wb_count
);
  import pipe_pkg::*;

  logic commit;
  logic [COUNT_W-1:0] wb_count_reg;
  logic [COUNT_W-1:0] wb_count_next;

  assign wdi = wm2reg ? wmo : walu;

  // Gating with resetn also suppresses the read bypass while in reset.
  assign commit = wwreg && (wrn != '0) && resetn;

  pipe_regfile #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clock     (clock),
    .resetn    (resetn),
    .wr_en     (commit),
    .wr_addr   (wrn),
    .wr_data   (wdi),
    .rd_addr_a (rna),
    .rd_addr_b (rnb),
    .rd_data_a (qa),
    .rd_data_b (qb)
  );

  // Clear has priority over a same-cycle commit; the count never wraps.
  always_comb begin
    wb_count_next = wb_count_reg;
    if (cnt_clr) begin
      wb_count_next = '0;
    end else if (commit && (wb_count_reg != '1)) begin
      wb_count_next = wb_count_reg + COUNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wb_count_reg <= '0;
    end else begin
      wb_count_reg <= wb_count_next;
    end
  end

  assign wb_count = wb_count_reg;

endmodule

// File: tb/tb_pipe_wb_stage.sv
// Self-checking bench for pipe_wb_stage: directed scenarios plus randomized
// traffic against an array-based register-file/counter model.
module tb_pipe_wb_stage;

  logic        clock = 1'b0;
  logic        resetn;
  logic        wwreg;
  logic        wm2reg;
  logic [31:0] wmo;
  logic [31:0] walu;
  logic [4:0]  wrn;
  logic [4:0]  rna;
  logic [4:0]  rnb;
  logic        cnt_clr;
  logic [31:0] qa, qb, wdi, wb_count;
  logic [31:0] qa4, qb4, wdi4;
  logic [3:0]  wb_count4;

  int total = 0;
  int bad   = 0;

  // Model state
  logic [31:0] m_rf [32];
  logic [31:0] m_cnt;
  logic [3:0]  m_cnt4;

  always #5 clock = ~clock;

  pipe_wb_stage dut (
    .clock(clock), .resetn(resetn), .wwreg(wwreg), .wm2reg(wm2reg),
    .wmo(wmo), .walu(walu), .wrn(wrn), .rna(rna), .rnb(rnb),
    .cnt_clr(cnt_clr), .qa(qa), .qb(qb), .wdi(wdi), .wb_count(wb_count)
  );

  pipe_wb_stage #(.COUNT_W(4)) dut4 (
    .clock(clock), .resetn(resetn), .wwreg(wwreg), .wm2reg(wm2reg),
    .wmo(wmo), .walu(walu), .wrn(wrn), .rna(rna), .rnb(rnb),
    .cnt_clr(cnt_clr), .qa(qa4), .qb(qb4), .wdi(wdi4), .wb_count(wb_count4)
  );

  function automatic logic [31:0] m_wdi();
    return wm2reg ? wmo : walu;
  endfunction

  function automatic logic m_commit();
    return wwreg && (wrn != 5'd0) && resetn;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (m_commit() && idx == wrn) return m_wdi();
    return m_rf[idx];
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_cnt  = 32'd0;
    m_cnt4 = 4'd0;
  endtask

  // Advance one clock edge, updating the model from the inputs seen at the edge.
  task automatic tick();
    logic        c;
    logic        clr;
    logic [31:0] d;
    logic [4:0]  a;
    c   = m_commit();
    clr = cnt_clr;
    d   = m_wdi();
    a   = wrn;
    @(posedge clock);
    if (!resetn) begin
      m_clear();
    end else begin
      if (c) m_rf[a] = d;
      if (clr) begin
        m_cnt  = 32'd0;
        m_cnt4 = 4'd0;
      end else if (c) begin
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        if (m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 4'd1;
      end
    end
    #1;
  endtask

  task automatic drive(input logic we, input logic m2r, input logic [31:0] mo,
                       input logic [31:0] alu, input logic [4:0] rn,
                       input logic [4:0] a, input logic [4:0] b, input logic clr);
    wwreg = we; wm2reg = m2r; wmo = mo; walu = alu; wrn = rn;
    rna = a; rnb = b; cnt_clr = clr;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    drive(1'b1, 1'b0, 32'h0, 32'h55, 5'd3, 5'd3, 5'd3, 1'b0);
    repeat (3) tick();
    total++;
    if (qa !== 32'd0) begin bad++; $display("FAIL reset_qa_held got=%h exp=%h", qa, 32'd0); end
    total++;
    if (wdi !== 32'h55) begin bad++; $display("FAIL reset_wdi got=%h exp=%h", wdi, 32'h55); end
    resetn = 1'b1;
    wwreg  = 1'b0;
    #1;
    total++;
    if (qa !== 32'd0) begin bad++; $display("FAIL reset_qa_release got=%h exp=%h", qa, 32'd0); end
    total++;
    if (wb_count !== 32'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", wb_count); end
    $display("reset: qa=%h wb_count=%0d", qa, wb_count);
  endtask

  task automatic test_alu_wb();
    drive(1'b1, 1'b0, 32'hCAFE_0000, 32'h1234_5678, 5'd5, 5'd1, 5'd2, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0, 1'b0);
    #1;
    total++;
    if (qa !== 32'h1234_5678) begin bad++; $display("FAIL alu_wb_qa got=%h exp=%h", qa, 32'h1234_5678); end
    total++;
    if (wb_count !== 32'd1) begin bad++; $display("FAIL alu_wb_count got=%0d exp=1", wb_count); end
    $display("alu_wb: r5=%h wb_count=%0d", qa, wb_count);
  endtask

  task automatic test_load_bypass();
    drive(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1111_2222, 5'd7, 5'd7, 5'd7, 1'b0);
    #2;
    total++;
    if (qa !== 32'hDEAD_BEEF) begin bad++; $display("FAIL bypass_qa got=%h exp=%h", qa, 32'hDEAD_BEEF); end
    total++;
    if (qb !== 32'hDEAD_BEEF) begin bad++; $display("FAIL bypass_qb got=%h exp=%h", qb, 32'hDEAD_BEEF); end
    total++;
    if (wdi !== 32'hDEAD_BEEF) begin bad++; $display("FAIL bypass_wdi got=%h exp=%h", wdi, 32'hDEAD_BEEF); end
    tick();
    wwreg = 1'b0;
    #1;
    total++;
    if (qa !== 32'hDEAD_BEEF) begin bad++; $display("FAIL load_stored got=%h exp=%h", qa, 32'hDEAD_BEEF); end
    $display("load_bypass: qa=%h qb=%h wdi=%h", qa, qb, wdi);
  endtask

  task automatic test_r0();
    logic [31:0] cnt_before;
    cnt_before = wb_count;
    drive(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    total++;
    if (qa !== 32'd0) begin bad++; $display("FAIL r0_before got=%h exp=0", qa); end
    tick();
    total++;
    if (qa !== 32'd0) begin bad++; $display("FAIL r0_after got=%h exp=0", qa); end
    total++;
    if (wb_count !== m_cnt) begin bad++; $display("FAIL r0_count got=%0d exp=%0d", wb_count, m_cnt); end
    $display("r0: qa=%h count %0d -> %0d", qa, cnt_before, wb_count);
  endtask

  task automatic test_cnt_clr();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd2, 5'd0, 1'b1);
    tick();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b0, 32'h0, $urandom, 5'(10 + i), 5'd2, 5'd0, 1'b0);
      tick();
    end
    total++;
    if (wb_count !== 32'd9) begin bad++; $display("FAIL clr_precount got=%0d exp=9", wb_count); end
    drive(1'b1, 1'b0, 32'h0, 32'h0BAD_F00D, 5'd2, 5'd2, 5'd2, 1'b1);
    tick();
    cnt_clr = 1'b0;
    wwreg   = 1'b0;
    #1;
    total++;
    if (wb_count !== 32'd0) begin bad++; $display("FAIL clr_vs_commit got=%0d exp=0", wb_count); end
    total++;
    if (qa !== 32'h0BAD_F00D) begin bad++; $display("FAIL clr_reg_write got=%h exp=%h", qa, 32'h0BAD_F00D); end
    $display("cnt_clr: wb_count=%0d r2=%h", wb_count, qa);
  endtask

  task automatic test_saturation();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b1);
    tick();
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 1'b1, $urandom, 32'h0, 5'($urandom_range(1, 31)), 5'd0, 5'd0, 1'b0);
      tick();
    end
    total++;
    if (wb_count4 !== 4'hF) begin bad++; $display("FAIL sat_full got=%h exp=f", wb_count4); end
    drive(1'b1, 1'b0, 32'h0, $urandom, 5'd9, 5'd0, 5'd0, 1'b0);
    tick();
    wwreg = 1'b0;
    total++;
    if (wb_count4 !== 4'hF) begin bad++; $display("FAIL sat_hold got=%h exp=f", wb_count4); end
    total++;
    if (wb_count !== 32'd16) begin bad++; $display("FAIL sat_wide got=%0d exp=16", wb_count); end
    $display("saturation: wb_count4=%h wb_count=%0d", wb_count4, wb_count);
  endtask

  task automatic test_random();
    logic [4:0]  rn;
    logic [31:0] ea, eb, ew;
    for (int n = 0; n < 300; n++) begin
      rn = 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 9) < 7), 1'($urandom), $urandom, $urandom, rn,
            ($urandom_range(0, 2) == 0) ? rn : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? rn : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 19) == 0));
      #2;
      ea = m_read(rna);
      eb = m_read(rnb);
      ew = m_wdi();
      total++;
      if (qa !== ea) begin bad++; $display("FAIL rand_qa n=%0d rna=%0d got=%h exp=%h", n, rna, qa, ea); end
      total++;
      if (qb !== eb) begin bad++; $display("FAIL rand_qb n=%0d rnb=%0d got=%h exp=%h", n, rnb, qb, eb); end
      total++;
      if (wdi !== ew) begin bad++; $display("FAIL rand_wdi n=%0d got=%h exp=%h", n, wdi, ew); end
      tick();
      total++;
      if (wb_count !== m_cnt) begin bad++; $display("FAIL rand_count n=%0d got=%0d exp=%0d", n, wb_count, m_cnt); end
      total++;
      if (wb_count4 !== m_cnt4) begin bad++; $display("FAIL rand_count4 n=%0d got=%0d exp=%0d", n, wb_count4, m_cnt4); end
      $display("rand n=%0d we=%0b rn=%0d ra=%0d rb=%0d qa=%h qb=%h cnt=%0d", n, wwreg, wrn, rna, rnb, qa, qb, wb_count);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b0, 32'h0, 32'hA5, 5'd4, 5'd4, 5'd4, 1'b0);
    tick();
    wwreg = 1'b0;
    #1;
    total++;
    if (qa !== 32'hA5) begin bad++; $display("FAIL async_pre got=%h exp=%h", qa, 32'hA5); end
    #2;
    resetn = 1'b0;
    m_clear();
    #1;
    total++;
    if (qa !== 32'd0) begin bad++; $display("FAIL async_immediate got=%h exp=0", qa); end
    total++;
    if (wb_count !== 32'd0) begin bad++; $display("FAIL async_count got=%0d exp=0", wb_count); end
    #1;
    resetn = 1'b1;
    tick();
    total++;
    if (qb !== 32'd0) begin bad++; $display("FAIL async_after got=%h exp=0", qb); end
    $display("async_reset: r4=%h wb_count=%0d", qb, wb_count);
  endtask

  initial begin
    m_clear();
    test_reset();
    test_alu_wb();
    test_load_bypass();
    test_r0();
    test_cnt_clr();
    test_saturation();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_wb_stage.md
Name: pipe_wb_stage

Overview:
- Writeback stage directly downstream of the MEM/WB pipeline register in the 5-stage pipeline.
- Selects writeback data: memory output when the load flag is set, otherwise the ALU result.
- Commits the data into the 32-entry general register file and serves the ID stage's two combinational read ports, with same-cycle write-through bypass.
- Keeps a retired-register-write counter for performance monitoring.

Parameters:
- DATA_W, 32, register and data width.
- ADDR_W, 5, register index width (2**ADDR_W registers, r0 hardwired zero).
- COUNT_W, 32, width of the retired-write counter.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- resetn  in  1  asynchronous, active-low reset.
- wwreg  in  1  register write enable from MEM/WB.
- wm2reg  in  1  1 = write memory data, 0 = write ALU result.
- wmo  in  DATA_W  memory read data from MEM/WB.
- walu  in  DATA_W  ALU result from MEM/WB.
- wrn  in  ADDR_W  destination register index.
- rna  in  ADDR_W  ID-stage read index A.
- rnb  in  ADDR_W  ID-stage read index B.
- cnt_clr  in  1  synchronous clear of the retired-write counter.
- qa  out  DATA_W  read data A (combinational).
- qb  out  DATA_W  read data B (combinational).
- wdi  out  DATA_W  selected writeback data, also used for forwarding.
- wb_count  out  COUNT_W  number of committed writes to r1..r31.

Behaviour:
- Clocking and reset: one clock (clock), reset asynchronous active-low (resetn).
- wdi = wm2reg ? wmo : walu. Purely combinational, no latency.
- Commit condition: commit = wwreg && (wrn != 0) && resetn.
- On posedge clock with commit, reg[wrn] <= wdi. Write latency is 1 edge.
- Writes to r0 are discarded.
- Reads are combinational:
  - qa = (rna == 0) ? 0 : (commit && rna == wrn) ? wdi : reg[rna]. qb is the same with rnb.
  - The bypass lets an instruction in ID see a value being written back in the same cycle.
- Both read ports may address the same register. Both may hit the bypass simultaneously.
- Reset (resetn = 0, asynchronous assertion): reg[1..31] = 0, wb_count = 0.
  - qa = qb = 0, because the bypass is gated by resetn.
  - wdi follows its inputs combinationally.
  - Reset asserted mid-operation discards any in-flight write at that edge.
  - After deassertion, the first write can occur at the next posedge.
- Counter, evaluated at posedge, in priority order:
  1. cnt_clr = 1 → wb_count <= 0. Clear wins over a simultaneous commit; that commit is not counted.
  2. Else if commit and wb_count != all-ones → wb_count + 1.
  3. The counter saturates at 2**COUNT_W-1 and never wraps.
- Writes with wwreg = 0 or wrn = 0 change neither the register file nor the counter.
- No handshake, no stall input. The stage accepts one writeback per cycle unconditionally.

Decomposition:
- Shared package pipe_pkg:
  - DATA_W, REG_ADDR_W, REG_ZERO (5'd0).
  - Register-index typedef and data-word typedef, shared with the ID and pipeline-register stages.
- One sub-module, pipe_regfile: storage array, reset, write port, two bypassed read ports.
- The top level holds the wdi mux, commit logic and counter.

Test Plan:
- Reset: hold resetn = 0 with wwreg = 1, wrn = 3, walu = 0x55. Then release and read rna = 3 → qa = 0, wb_count = 0.
- ALU writeback: wwreg = 1, wm2reg = 0, wrn = 5, walu = 0x1234_5678 for one edge. Next cycle rna = 5 → qa = 0x1234_5678, wb_count = 1.
- Load writeback with bypass: wm2reg = 1, wmo = 0xDEAD_BEEF, wrn = 7, rna = rnb = 7 in the same cycle before the edge → qa = qb = 0xDEAD_BEEF, wdi = 0xDEAD_BEEF.
- r0 protection: wwreg = 1, wrn = 0, walu = 0xFFFF_FFFF → rna = 0 gives qa = 0 both before and after the edge, and wb_count is unchanged.
- Counter clear vs. commit: counter = 9, assert cnt_clr together with a valid write to r2 → wb_count = 0 and reg[2] is updated. Separately, preload all-ones (COUNT_W = 4 build) plus one more commit → stays 0xF.
- Async reset mid-stream: after writing r4 = 0xA5, pulse resetn low between clock edges → qa for r4 is 0 immediately and remains 0 after release.
